// File: rtl/palette_lut_animated.sv
// Programmable colour-code to RGB palette with optional palette-cycling rotation; 2-cycle latency.
// No backpressure (one code per clock); optional transparent_out under PALETTE_TRANSPARENCY_EN.
module palette_lut_animated #(
    parameter int CODE_W           = 3,
    parameter int RGB_W            = 8,
    parameter int CYCLE_FRAMES     = 16,
    parameter int TRANSPARENT_CODE = 0
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] wr_addr,
    input  logic [RGB_W-1:0]  wr_data,
    input  logic              cycle_en,
    input  logic              offset_clr,
    output logic [RGB_W-1:0]  rgb_out,
    output logic              rgb_valid,
    output logic [CODE_W-1:0] offset_out
`ifdef PALETTE_TRANSPARENCY_EN
    ,
    output logic              transparent_out
`endif
);

    localparam int N = 1 << CODE_W;
    localparam logic [7:0]        CNT_LAST = 8'(CYCLE_FRAMES - 1);
    localparam logic [CODE_W-1:0] OFF_ONE  = {{(CODE_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, COUNT} state_t;

    logic [RGB_W-1:0]  palette [N];
    logic [CODE_W-1:0] eff_addr;
    logic [CODE_W-1:0] s1_addr;
    logic              s1_vld;
    logic [7:0]        frame_cnt;
    state_t            state;

    function automatic logic [7:0] default_low(input int idx);
        case (idx)
            0:       return 8'hCC;
            1:       return 8'h59;
            2:       return 8'hDA;
            3:       return 8'h5B;
            4:       return 8'h4D;
            5:       return 8'h78;
            6:       return 8'hD8;
            7:       return 8'hEE;
            default: return 8'h00;
        endcase
    endfunction

    assign eff_addr = code_in + offset_out;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < N; i++) begin
                palette[i] <= RGB_W'(default_low(i));
            end
        end else if (wr_en) begin
            palette[wr_addr] <= wr_data;
        end
    end

    // Stage 2 reads the pre-edge palette, so a same-cycle write to the entry returns the old value.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            s1_vld    <= 1'b0;
            s1_addr   <= '0;
            rgb_valid <= 1'b0;
            rgb_out   <= '0;
        end else begin
            s1_vld    <= code_valid;
            s1_addr   <= eff_addr;
            rgb_valid <= s1_vld;
            if (s1_vld) begin
                rgb_out <= palette[s1_addr];
            end
        end
    end

`ifdef PALETTE_TRANSPARENCY_EN
    localparam logic [CODE_W-1:0] TP_CODE = CODE_W'(TRANSPARENT_CODE);
    logic s1_tr;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            s1_tr           <= 1'b0;
            transparent_out <= 1'b0;
        end else begin
            s1_tr           <= code_valid && (code_in == TP_CODE);
            transparent_out <= s1_vld && s1_tr;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            offset_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    frame_cnt <= '0;
                    if (cycle_en) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!cycle_en) begin
                        state     <= IDLE;
                        frame_cnt <= '0;
                    end else if (startOfFrame) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt  <= '0;
                            offset_out <= offset_out + OFF_ONE;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Clear wins over any rotation step in the same cycle.
            if (offset_clr) begin
                offset_out <= '0;
                frame_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_palette_lut_animated.sv
// Scoreboard bench: a palette/rotation reference model queues expected outputs, a monitor pops and compares.
module tb_palette_lut_animated;

    localparam int CODE_W = 3;
    localparam int RGB_W  = 8;
    localparam int CF     = 2;
    localparam int TC     = 0;
    localparam int N      = 8;
    localparam logic [7:0] DEF [8] = '{8'hCC, 8'h59, 8'hDA, 8'h5B, 8'h4D, 8'h78, 8'hD8, 8'hEE};

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              startOfFrame = 1'b0;
    logic [CODE_W-1:0] code_in = '0;
    logic              code_valid = 1'b0;
    logic              wr_en = 1'b0;
    logic [CODE_W-1:0] wr_addr = '0;
    logic [RGB_W-1:0]  wr_data = '0;
    logic              cycle_en = 1'b0;
    logic              offset_clr = 1'b0;
    logic [RGB_W-1:0]  rgb_out;
    logic              rgb_valid;
    logic [CODE_W-1:0] offset_out;
`ifdef PALETTE_TRANSPARENCY_EN
    logic              transparent_out;
`endif

    always #5 clk = ~clk;

    palette_lut_animated #(
        .CODE_W(CODE_W), .RGB_W(RGB_W), .CYCLE_FRAMES(CF), .TRANSPARENT_CODE(TC)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .code_in(code_in), .code_valid(code_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cycle_en(cycle_en), .offset_clr(offset_clr),
        .rgb_out(rgb_out), .rgb_valid(rgb_valid), .offset_out(offset_out)
`ifdef PALETTE_TRANSPARENCY_EN
        , .transparent_out(transparent_out)
`endif
    );

    typedef struct {
        logic [7:0] rgb;
        logic       tr;
    } exp_t;

    exp_t       q[$];
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] m_pal [N];
    int         m_off = 0;
    int         m_cnt = 0;
    bit         m_en_prev = 1'b0;
    bit         pend_v = 1'b0;
    int         pend_addr = 0;
    bit         pend_tr = 1'b0;
    logic [7:0] m_last = '0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: behaviour of one rising edge, from the palette/rotation rules.
    always @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < N; i++) m_pal[i] = DEF[i];
            m_off = 0; m_cnt = 0; m_en_prev = 1'b0;
            pend_v = 1'b0; m_last = '0;
            q.delete();
        end else begin
            if (pend_v) begin
                q.push_back('{m_pal[pend_addr], pend_tr});
                m_last = m_pal[pend_addr];
            end
            if (wr_en) m_pal[wr_addr] = wr_data;
            pend_v    = code_valid;
            pend_addr = (int'(code_in) + m_off) % N;
            pend_tr   = (int'(code_in) == TC);
            if (offset_clr) begin
                m_off = 0; m_cnt = 0;
            end else if (!cycle_en || !m_en_prev) begin
                m_cnt = 0;
            end else if (startOfFrame) begin
                m_cnt++;
                if (m_cnt == CF) begin
                    m_cnt = 0;
                    m_off = (m_off + 1) % N;
                end
            end
            m_en_prev = cycle_en;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check("offset_out", offset_out, m_off);
        if (rgb_valid) begin
            if (q.size() == 0) begin
                check("stray_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("rgb_out", rgb_out, e.rgb);
`ifdef PALETTE_TRANSPARENCY_EN
                check("transparent_out", transparent_out, e.tr);
`endif
            end
        end else begin
            if (q.size() != 0) begin
                check("missing_valid", 0, 1);
                void'(q.pop_front());
            end
            check("rgb_hold", rgb_out, m_last);
`ifdef PALETTE_TRANSPARENCY_EN
            check("transparent_idle", transparent_out, 0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        code_valid = 1'b0; wr_en = 1'b0; startOfFrame = 1'b0; offset_clr = 1'b0;
    endtask

    task automatic pulse();
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
    endtask

    initial begin
        idle();
        resetN = 1'b0;
        tick(); tick();
        check("reset_rgb", rgb_out, 0);
        check("reset_valid", rgb_valid, 0);
        check("reset_offset", offset_out, 0);
        resetN = 1'b1;
        tick();

        // Default palette readout.
        for (int i = 0; i < 8; i++) begin
            code_in = CODE_W'(i); code_valid = 1'b1; tick();
        end
        idle(); tick(); tick(); tick();

        // Write to entry 3 on the edge code 3 is read: old value, then new value.
        code_in = 3'd3; code_valid = 1'b1; tick();
        code_valid = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; tick();
        wr_en = 1'b0; code_valid = 1'b1; tick();
        idle(); tick(); tick();

        // Rotation with CYCLE_FRAMES = 2.
        cycle_en = 1'b1; tick(); tick();
        pulse(); check("rot_p1", offset_out, 0);
        pulse(); check("rot_p2", offset_out, 1);
        pulse(); check("rot_p3", offset_out, 1);
        pulse(); check("rot_p4", offset_out, 2);
        code_in = 3'd7; code_valid = 1'b1; tick();
        idle(); tick(); tick();

        // Wrap from 7 back to 0.
        for (int i = 0; i < 10; i++) pulse();
        check("rot_at7", offset_out, 7);
        pulse(); pulse();
        check("rot_wrap", offset_out, 0);

        // Clear beats a rotation-triggering pulse and resets the counter.
        pulse(); pulse(); pulse();
        check("pre_clr", offset_out, 1);
        startOfFrame = 1'b1; offset_clr = 1'b1; tick();
        idle(); tick();
        check("clr_offset", offset_out, 0);
        pulse();
        check("clr_counter", offset_out, 0);

`ifdef PALETTE_TRANSPARENCY_EN
        pulse();
        for (int i = 0; i < 4; i++) pulse();
        check("tr_offset3", offset_out, 3);
        code_in = 3'd0; code_valid = 1'b1; tick();
        idle(); tick(); tick();
`endif

        // Reset with two codes in flight; palette returns to defaults.
        cycle_en = 1'b0;
        code_in = 3'd3; code_valid = 1'b1; tick();
        resetN = 1'b0; tick();
        resetN = 1'b1; idle(); tick();
        check("rst_mid_valid", rgb_valid, 0);
        check("rst_mid_rgb", rgb_out, 0);
        code_in = 3'd3; code_valid = 1'b1; tick();
        idle(); tick(); tick();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            resetN       = ($urandom_range(0, 199) != 0);
            code_valid   = $urandom_range(0, 3) != 0;
            code_in      = CODE_W'($urandom_range(0, N - 1));
            wr_en        = $urandom_range(0, 7) == 0;
            wr_addr      = CODE_W'($urandom_range(0, N - 1));
            wr_data      = RGB_W'($urandom);
            startOfFrame = $urandom_range(0, 3) == 0;
            cycle_en     = $urandom_range(0, 15) != 0;
            offset_clr   = $urandom_range(0, 31) == 0;
            tick();
        end
        resetN = 1'b1; idle();
        for (int i = 0; i < 5; i++) tick();
        check("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
